// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared constants, FSM states and operand-select helpers for mont_stream_loader
package mont_pkg;

  localparam int DATA_W  = 512;
  localparam int WORD_W  = 32;
  localparam int N_WORDS = DATA_W / WORD_W;
  localparam int CNT_W   = 16;
  localparam int SLICE_W = $clog2(N_WORDS);
  localparam int IDX_W   = $clog2(3 * N_WORDS);

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    OP_A,
    OP_B,
    OP_M
  } op_sel_t;

  // Input transfer k lands in operand k/N_WORDS, slice k%N_WORDS.
  function automatic op_sel_t op_of(input logic [IDX_W-1:0] k);
    if (k < IDX_W'(N_WORDS)) return OP_A;
    else if (k < IDX_W'(2 * N_WORDS)) return OP_B;
    else return OP_M;
  endfunction

  function automatic logic [SLICE_W-1:0] slice_of(input logic [IDX_W-1:0] k);
    return SLICE_W'(k % IDX_W'(N_WORDS));
  endfunction

  function automatic logic [WORD_W-1:0] word_at(input logic [DATA_W-1:0] v,
                                                input logic [SLICE_W-1:0] i);
    return v[i*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/word_shift_reg.sv
// rtl/word_shift_reg.sv - wide register with indexed word write and whole-value load
module word_shift_reg #(
  parameter int WIDTH = 512,
  parameter int WORD  = 32,
  parameter int IW    = $clog2(WIDTH / WORD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [WORD-1:0]  wr_data,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load_en) begin
      value <= load_data;
    end else if (wr_en) begin
      value[wr_idx*WORD +: WORD] <= wr_data;
    end
  end

endmodule

// File: rtl/mont_stream_loader.sv
// rtl/mont_stream_loader.sv - word-stream loader/drainer and latency meter around the montgomery core
module mont_stream_loader
  import mont_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              mm_start,
  output logic [DATA_W-1:0] mm_in_a,
  output logic [DATA_W-1:0] mm_in_b,
  output logic [DATA_W-1:0] mm_in_m,
  input  logic [DATA_W-1:0] mm_result,
  input  logic              mm_done,
  output logic              busy,
  output logic [CNT_W-1:0]  mm_cycles
);

  localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(3 * N_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state;
  state_t             state_nx;
  logic               primed;
  logic [IDX_W-1:0]   cnt;
  logic [DATA_W-1:0]  result_q;
  op_sel_t            op;
  logic [SLICE_W-1:0] slice;
  logic               xfer_in;
  logic               xfer_out;
  logic               capture;

  // cnt walks 0..47 while loading and doubles as the drain word index.
  assign op       = op_of(cnt);
  assign slice    = slice_of(cnt);
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;
  assign capture  = (state == S_WAIT) && mm_done;
  assign out_last = (state == S_DRAIN) && (cnt == LAST_IDX);
  assign out_data = word_at(result_q, cnt[SLICE_W-1:0]);

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mm_start  = 1'b0;
    busy      = 1'b1;
    case (state)
      S_LOAD: begin
        busy     = 1'b0;
        in_ready = primed;
        if (in_valid && primed && (cnt == LAST_K)) state_nx = S_START;
      end
      S_START: begin
        mm_start = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (mm_done) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (cnt == LAST_IDX)) state_nx = S_LOAD;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  // primed keeps in_ready low until the first edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_LOAD;
      primed    <= 1'b0;
      cnt       <= '0;
      mm_cycles <= '0;
    end else begin
      state  <= state_nx;
      primed <= 1'b1;
      case (state)
        S_LOAD:  if (xfer_in) cnt <= (cnt == LAST_K) ? '0 : cnt + 1'b1;
        S_DRAIN: if (xfer_out) cnt <= out_last ? '0 : cnt + 1'b1;
        default: ;
      endcase
      if (state == S_START) begin
        mm_cycles <= '0;
      end else if ((state == S_WAIT) && (mm_cycles != CNT_MAX)) begin
        mm_cycles <= mm_cycles + 1'b1;
      end
    end
  end

  word_shift_reg #(.WIDTH(DATA_W), .WORD(WORD_W)) u_op_a (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (xfer_in && (op == OP_A)),
    .wr_idx    (slice),
    .wr_data   (in_data),
    .load_en   (1'b0),
    .load_data ('0),
    .value     (mm_in_a)
  );

  word_shift_reg #(.WIDTH(DATA_W), .WORD(WORD_W)) u_op_b (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (xfer_in && (op == OP_B)),
    .wr_idx    (slice),
    .wr_data   (in_data),
    .load_en   (1'b0),
    .load_data ('0),
    .value     (mm_in_b)
  );

  word_shift_reg #(.WIDTH(DATA_W), .WORD(WORD_W)) u_op_m (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (xfer_in && (op == OP_M)),
    .wr_idx    (slice),
    .wr_data   (in_data),
    .load_en   (1'b0),
    .load_data ('0),
    .value     (mm_in_m)
  );

  word_shift_reg #(.WIDTH(DATA_W), .WORD(WORD_W)) u_result (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .load_en   (capture),
    .load_data (mm_result),
    .value     (result_q)
  );

endmodule

// File: tb/tb_mont_stream_loader.sv
// tb/tb_mont_stream_loader.sv - self-checking bench for mont_stream_loader with a stub multiplier
module tb_mont_stream_loader;

  localparam int NW  = 16;
  localparam int NIN = 3 * NW;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         out_last;
  logic         mm_start;
  logic [511:0] mm_in_a;
  logic [511:0] mm_in_b;
  logic [511:0] mm_in_m;
  logic [511:0] mm_result = '0;
  logic         mm_done = 1'b0;
  logic         busy;
  logic [15:0]  mm_cycles;

  int errors = 0;
  int checks = 0;

  logic [31:0] in_words [NIN];
  int stub_delay = 5;
  int stub_k = 0;
  bit stub_armed = 1'b0;
  bit spurious = 1'b0;
  logic [15:0] last_cycles = '0;

  mont_stream_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .mm_start  (mm_start),
    .mm_in_a   (mm_in_a),
    .mm_in_b   (mm_in_b),
    .mm_in_m   (mm_in_m),
    .mm_result (mm_result),
    .mm_done   (mm_done),
    .busy      (busy),
    .mm_cycles (mm_cycles)
  );

  always #5 clk = ~clk;

  // Stub multiplier: mm_done arrives in the stub_delay-th cycle after the start cycle.
  always @(negedge clk) begin
    if (mm_start) begin
      stub_k = stub_delay;
      stub_armed = 1'b1;
      mm_done = 1'b0;
    end else if (stub_armed) begin
      stub_k = stub_k - 1;
      mm_done = (stub_k == 0);
      if (stub_k == 0) stub_armed = 1'b0;
    end else begin
      mm_done = spurious;
    end
  end

  function automatic logic [511:0] model_operand(input int op);
    logic [511:0] v;
    v = '0;
    for (int s = 0; s < NW; s++) v[s*32 +: 32] = in_words[op*NW + s];
    return v;
  endfunction

  function automatic logic [15:0] model_cycles(input int d);
    return (d > 65535) ? 16'hFFFF : 16'(d);
  endfunction

  task automatic fill_random();
    for (int k = 0; k < NIN; k++) in_words[k] = $urandom;
    for (int s = 0; s < NW; s++) mm_result[s*32 +: 32] = $urandom;
  endtask

  // Presents all 48 words, then checks the start pulse and the assembled operands.
  task automatic load_op(input int gap_at, input int gap_len);
    int i;
    int gap;
    int budget;
    i = 0;
    gap = gap_len;
    budget = 500;
    while (i < NIN && budget > 0) begin
      @(negedge clk);
      budget--;
      if (i == gap_at && gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = 1'b1;
        in_data = in_words[i];
        if (in_ready) i++;
      end
    end
    checks++;
    if (i != NIN) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d words, required %0d", i, NIN);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (mm_start !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse: start=%b busy=%b in_ready=%b, required 1 1 0", mm_start, busy, in_ready);
    end
    checks++;
    if (mm_in_a !== model_operand(0)) begin
      errors++;
      $display("FAIL operand_a: got %h required %h", mm_in_a, model_operand(0));
    end
    checks++;
    if (mm_in_b !== model_operand(1)) begin
      errors++;
      $display("FAIL operand_b: got %h required %h", mm_in_b, model_operand(1));
    end
    checks++;
    if (mm_in_m !== model_operand(2)) begin
      errors++;
      $display("FAIL operand_m: got %h required %h", mm_in_m, model_operand(2));
    end
  endtask

  // From the start cycle, waits for the first out_valid; optionally offers input words meanwhile.
  task automatic await_result(input bit poke);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (n < stub_delay + 50) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if (mm_start !== 1'b0) begin
          errors++;
          $display("FAIL start_width: mm_start=%b one cycle later, required 0", mm_start);
        end
      end
      if (out_valid === 1'b1) break;
      if (poke) begin
        in_valid = 1'b1;
        in_data = $urandom;
      end
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (n != stub_delay + 1) begin
      errors++;
      $display("FAIL done_to_valid: out_valid after %0d cycles, required %0d", n, stub_delay + 1);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ready_while_busy: %0d cycles with in_ready=1 or busy=0, required 0", bad);
    end
    checks++;
    if (mm_in_a !== model_operand(0) || mm_in_b !== model_operand(1) || mm_in_m !== model_operand(2)) begin
      errors++;
      $display("FAIL operand_hold: a=%h required %h", mm_in_a, model_operand(0));
    end
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1,0,0...
  task automatic drain(input int mode, input int stop_after, output int beats);
    int cyc;
    bit prev_stall;
    logic [31:0] prev_data;
    logic prev_last;
    beats = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    while (beats < stop_after && cyc < 200) begin
      if (prev_stall) begin
        checks++;
        if (out_data !== prev_data || out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: data=%h last=%b, required %h %b", out_data, out_last, prev_data, prev_last);
        end
      end
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (out_ready) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== mm_result[beats*32 +: 32] || out_last !== (beats == NW - 1)) begin
          errors++;
          $display("FAIL drain_beat%0d: valid=%b data=%h last=%b, required 1 %h %b", beats, out_valid,
                   out_data, out_last, mm_result[beats*32 +: 32], beats == NW - 1);
        end
        beats++;
      end
      prev_stall = !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic run_op(input int gap_at, input int gap_len, input bit poke, input int mode);
    int beats;
    load_op(gap_at, gap_len);
    await_result(poke);
    drain(mode, NW, beats);
    checks++;
    if (beats != NW || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL beat_count: %0d beats, out_valid=%b after, required %0d and 0", beats, out_valid, NW);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL return_to_load: in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    last_cycles = model_cycles(stub_delay);
    checks++;
    if (mm_cycles !== last_cycles) begin
      errors++;
      $display("FAIL mm_cycles: got %0d required %0d", mm_cycles, last_cycles);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({in_ready, out_valid, out_last, mm_start, busy} !== 5'b0 || mm_cycles !== 16'h0 ||
        (mm_in_a | mm_in_b | mm_in_m) !== 512'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b ov=%b last=%b start=%b busy=%b cyc=%0d, required all 0",
               in_ready, out_valid, out_last, mm_start, busy, mm_cycles);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: in_ready=%b required 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_edge: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic_round_trip();
    for (int k = 0; k < NIN; k++) in_words[k] = 32'(k);
    for (int s = 0; s < NW; s++) mm_result[s*32 +: 32] = 32'hA000_0000 + 32'(s);
    stub_delay = 5;
    run_op(-1, 0, 1'b0, 0);
    checks++;
    if (mm_in_a[31:0] !== 32'h0 || mm_in_b[31:0] !== 32'h10 || mm_in_m[511:480] !== 32'h2F) begin
      errors++;
      $display("FAIL basic_slices: a0=%h b0=%h m15=%h, required 0 10 2f", mm_in_a[31:0], mm_in_b[31:0],
               mm_in_m[511:480]);
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    stub_delay = $urandom_range(1, 20);
    run_op(-1, 0, 1'b0, 1);
  endtask

  task automatic test_input_gaps();
    fill_random();
    stub_delay = 8;
    run_op(21, 3, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      fill_random();
      stub_delay = $urandom_range(1, 12);
      run_op(-1, 0, 1'b0, r);
    end
  endtask

  task automatic test_reset_mid();
    int beats;
    fill_random();
    stub_delay = 30;
    load_op(-1, 0);
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    stub_armed = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, mm_start, busy} !== 5'b0 || mm_cycles !== 16'h0 ||
        (mm_in_a | mm_in_b | mm_in_m) !== 512'h0) begin
      errors++;
      $display("FAIL reset_in_wait: rdy=%b ov=%b start=%b busy=%b cyc=%0d, required all 0",
               in_ready, out_valid, mm_start, busy, mm_cycles);
    end
    @(negedge clk);
    reset = 1'b0;
    fill_random();
    stub_delay = 4;
    load_op(-1, 0);
    await_result(1'b0);
    drain(0, 7, beats);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (beats != 7 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || mm_cycles !== 16'h0) begin
      errors++;
      $display("FAIL reset_in_drain: beats=%0d ov=%b last=%b busy=%b cyc=%0d, required 7 0 0 0 0",
               beats, out_valid, out_last, busy, mm_cycles);
    end
    @(negedge clk);
    reset = 1'b0;
    fill_random();
    stub_delay = 6;
    run_op(-1, 0, 1'b0, 0);
  endtask

  task automatic test_saturation();
    int bad;
    bad = 0;
    spurious = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || out_valid !== 1'b0 || mm_cycles !== last_cycles) bad++;
    end
    spurious = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL spurious_done: %0d cycles disturbed, required 0", bad);
    end
    fill_random();
    stub_delay = 70000;
    run_op(-1, 0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_round_trip();
    test_backpressure();
    test_input_gaps();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/mont_stream_loader.md
Name: mont_stream_loader

Overview:
- Upstream/downstream wrapper stage for the 512-bit `montgomery` multiplier.
- Accepts operands A, B, M as a valid/ready stream of 32-bit words and assembles them into 512-bit registers.
- Pulses `start` to the multiplier, waits for `done`, captures `result`, then streams the result back out as 32-bit words.
- Sits between the bus/DMA word interface and the multiplier core; also measures multiplier latency.

Parameters:
- DATA_W, 512, operand/result width; must equal the multiplier width.
- WORD_W, 32, stream word width; DATA_W must be a multiple of WORD_W.
- N_WORDS, DATA_W/WORD_W (16), words per operand; derived, not overridable.
- CNT_W, 16, width of the latency counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset; one clock; the multiplier's active-low resetn is driven by the integrator as ~reset
- in_valid  input  1  input word valid
- in_ready  output  1  loader accepts a word this cycle
- in_data  input  WORD_W  operand word
- out_valid  output  1  result word valid
- out_ready  input  1  consumer accepts a result word
- out_data  output  WORD_W  result word
- out_last  output  1  marks the final result word
- mm_start  output  1  one-cycle start pulse to the multiplier
- mm_in_a  output  DATA_W  operand A to the multiplier
- mm_in_b  output  DATA_W  operand B to the multiplier
- mm_in_m  output  DATA_W  modulus M to the multiplier
- mm_result  input  DATA_W  multiplier result
- mm_done  input  1  multiplier done
- busy  output  1  high in every state except S_LOAD
- mm_cycles  output  CNT_W  latency of the last multiplication

Behaviour:
- Reset values (async, all immediately 0):
  - in_ready, out_valid, out_last, mm_start, busy, mm_cycles = 0.
  - mm_in_a, mm_in_b, mm_in_m, result register, word counter = 0.
  - State = S_LOAD. in_ready rises on the first clock edge after reset deasserts.
- Reset mid-operation: same as power-up. Partial loads are discarded, an in-flight start is dropped, and the drain is aborted with no out_last.
- FSM states: S_LOAD, S_START, S_WAIT, S_DRAIN.
- S_LOAD:
  - in_ready = 1. A transfer occurs when in_valid && in_ready.
  - Transfer k (0..3*N_WORDS-1) writes operand k/N_WORDS (0 = A, 1 = B, 2 = M), slice k%N_WORDS, least-significant word first.
  - On the transfer with k = 3*N_WORDS-1 (47): go to S_START, clear the counter.
  - in_valid while in_ready = 0 is ignored, with no side effects.
- S_START:
  - mm_start = 1 for exactly one cycle.
  - mm_cycles cleared to 0.
  - Next state is always S_WAIT.
- S_WAIT:
  - mm_cycles increments every cycle and saturates at 2^CNT_W-1.
  - On mm_done = 1: capture mm_result into the result register and go to S_DRAIN. mm_cycles includes that cycle.
  - mm_done in any other state is ignored.
- Operand hold: mm_in_a/b/m are stable from entry to S_START until the loader returns to S_LOAD. They change only on accepted input words.
- S_DRAIN:
  - out_valid = 1; out_data = result slice idx, LSW first.
  - out_last = 1 when idx = N_WORDS-1.
  - idx advances only on out_valid && out_ready.
  - out_data and out_last are held stable while out_ready = 0.
  - On the accepted last word: go to S_LOAD and clear idx. in_ready rises the next cycle; there is no same-cycle overlap.
- Latency:
  - 48 accepted words, then 1 cycle (S_START), then the multiplier time, then 16 output beats.
  - Back-to-back best case: final input word to mm_start is 1 cycle; mm_done to first out_valid is 1 cycle.
- mm_cycles holds its value until the next S_START.

Decomposition:
- Shared package `mont_pkg`:
  - DATA_W, WORD_W, N_WORDS constants.
  - FSM state enum: S_LOAD, S_START, S_WAIT, S_DRAIN.
  - Operand-select encoding.
- One sub-module is natural: `word_shift_reg`, a DATA_W register with indexed WORD_W write/read. Instantiated for A, B, M (write side) and for the result (read side).
- FSM and counters live in the top module.

Test Plan:
- Basic load:
  - Stimulus: reset; stream words 0x00000000..0x0000002F continuously.
  - Required: mm_in_a[31:0] = 0x0, mm_in_b[31:0] = 0x10, mm_in_m[511:480] = 0x2F; mm_start high exactly one cycle, one cycle after word 47.
- Round trip:
  - Stimulus: stub multiplier raises mm_done 5 cycles after start, with mm_result = {16 words 0xA0000000+i}; out_ready = 1.
  - Required: out_data sequence 0xA0000000..0xA000000F; out_last only on the 16th beat; mm_cycles = 5; return to S_LOAD.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1,... during drain.
  - Required: out_data/out_last held while stalled; exactly 16 beats; no word repeated or skipped.
- Input gaps:
  - Stimulus: in_valid low for 3 cycles between words 20 and 21; in_valid asserted during S_WAIT.
  - Required: operands unchanged by the gap; S_WAIT-cycle words ignored; in_ready = 0 while busy = 1.
- Reset mid-operation:
  - Stimulus: assert reset during S_WAIT, then during S_DRAIN at beat 7.
  - Required: all outputs 0 asynchronously; out_last never seen; a fresh 48-word load then completes correctly.
- Latency saturation:
  - Stimulus: stub holds mm_done = 0 for 70000 cycles.
  - Required: mm_cycles = 0xFFFF; spurious mm_done before start is ignored.
